// File: rtl/ps2_pkg.sv
// Shared scan-code constants, framing states and key event record for the PS/2 receiver.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  // "release" is a reserved word, hence "released".
  typedef struct packed {
    logic [7:0] code;
    logic       released;
    logic       extended;
  } key_event_t;

endpackage

// File: rtl/ps2_line_cond.sv
// Synchronizes the raw PS/2 lines and debounces ps2_clk into a single-cycle falling-edge strobe.
module ps2_line_cond #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall        <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      fall        <= 1'b0;
      // Count consecutive samples that disagree with the filtered level.
      if (clk_sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        filt_q <= clk_sync_q[1];
        cnt_q  <= '0;
        fall   <= filt_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign data = data_sync_q[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver: framing FSM with timeout, E0/F0 prefix folding,
// and a one-entry valid/ready holding register for key events.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned FILTER_CYCLES = 8,
  parameter int unsigned TIMEOUT_US    = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TIMEOUT_CYCLES = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1);

  logic          data;
  logic          fall;
  ps2_state_t    state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bitcnt_q;
  logic          parity_q;
  logic [TW-1:0] to_cnt_q;
  logic          byte_good_q;
  logic          ext_q;
  logic          brk_q;
  logic          evt;
  key_event_t    ev;

  ps2_line_cond #(
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_cond (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data     (data),
    .fall     (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      byte_good_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      byte_good_q <= 1'b0;
      if (state_q != IDLE && !fall && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q   <= IDLE;
        to_cnt_q  <= '0;
        frame_err <= 1'b1;
        ext_q     <= 1'b0;
        brk_q     <= 1'b0;
      end else if (fall) begin
        to_cnt_q <= '0;
        unique case (state_q)
          IDLE: begin
            if (!data) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end
          end
          DATA: begin
            shift_q  <= {data, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= data;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (data && (^{parity_q, shift_q})) begin
              byte_good_q <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              ext_q     <= 1'b0;
              brk_q     <= 1'b0;
            end
          end
        endcase
      end else if (state_q != IDLE) begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      // Prefix bytes only arm flags; any other good byte consumes them.
      if (byte_good_q) begin
        if (shift_q == SC_EXT) begin
          ext_q <= 1'b1;
        end else if (shift_q == SC_BREAK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
    end
  end

  assign evt = byte_good_q && (shift_q != SC_EXT) && (shift_q != SC_BREAK);

  always_comb begin
    ev          = '0;
    ev.code     = shift_q;
    ev.released = brk_q;
    ev.extended = ext_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid    <= 1'b0;
      key_code     <= '0;
      key_release  <= 1'b0;
      key_extended <= 1'b0;
      overrun      <= 1'b0;
    end else if (evt && (!key_valid || key_ready)) begin
      key_valid    <= 1'b1;
      key_code     <= ev.code;
      key_release  <= ev.released;
      key_extended <= ev.extended;
    end else if (evt) begin
      overrun <= 1'b1;
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: table of frame sequences plus hand-written corner cases.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_ready;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_release;
  logic       key_extended;
  logic       frame_err;
  logic       overrun;

  // 1 MHz system clock: one cycle per microsecond, timeout = 200 cycles.
  ps2_keyboard_rx #(
    .CLK_HZ        (1_000_000),
    .FILTER_CYCLES (8),
    .TIMEOUT_US    (200)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_ready    (key_ready),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_release  (key_release),
    .key_extended (key_extended),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int err_cnt = 0;
  int err_run = 0;
  int err_maxw = 0;
  int err_cyc = 0;
  int stop_cyc = 0;
  int lat = -1;
  logic kv_prev = 1'b0;
  logic [9:0] evq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid && key_ready) evq.push_back({key_code, key_release, key_extended});
    if (frame_err) begin
      err_run++;
      if (err_run == 1) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (err_run > err_maxw) err_maxw = err_run;
    end else begin
      err_run = 0;
    end
    if (dut.fall && dut.state_q == STOP) stop_cyc = cyc;
    if (key_valid && !kv_prev) lat = cyc - stop_cyc;
    kv_prev = key_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Data changes mid-high, clock low for 30 us: 60 us bit period.
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(15);
    ps2_clk = 1'b0;
    last_fall = cyc;
    tick(30);
    ps2_clk = 1'b1;
    tick(15);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad);
    ps2_bit(1'b1);
  endtask

  task automatic clear_mon();
    evq.delete();
    err_cnt = 0;
    err_maxw = 0;
  endtask

  typedef struct {
    int         nf;
    logic [7:0] f0, f1, f2;
    logic [2:0] bad;
    int         exp_n;
    logic [7:0] code;
    logic       rel;
    logic       ext;
    int         exp_err;
  } vec_t;

  function automatic vec_t mkv(input int nf, input logic [7:0] f0, input logic [7:0] f1,
                               input logic [7:0] f2, input logic [2:0] bad, input int exp_n,
                               input logic [7:0] code, input logic rel, input logic ext,
                               input int exp_err);
    vec_t v;
    v.nf = nf; v.f0 = f0; v.f1 = f1; v.f2 = f2; v.bad = bad;
    v.exp_n = exp_n; v.code = code; v.rel = rel; v.ext = ext; v.exp_err = exp_err;
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    tbl[0] = mkv(1, 8'h1C, 8'h00, 8'h00, 3'b000, 1, 8'h1C, 1'b0, 1'b0, 0);
    tbl[1] = mkv(2, 8'hF0, 8'h1C, 8'h00, 3'b000, 1, 8'h1C, 1'b1, 1'b0, 0);
    tbl[2] = mkv(3, 8'hE0, 8'hF0, 8'h75, 3'b000, 1, 8'h75, 1'b1, 1'b1, 0);
    tbl[3] = mkv(1, 8'h75, 8'h00, 8'h00, 3'b000, 1, 8'h75, 1'b0, 1'b0, 0);
    tbl[4] = mkv(1, 8'h1C, 8'h00, 8'h00, 3'b001, 0, 8'h00, 1'b0, 1'b0, 1);
    tbl[5] = mkv(1, 8'h29, 8'h00, 8'h00, 3'b000, 1, 8'h29, 1'b0, 1'b0, 0);
    tbl[6] = mkv(3, 8'hE0, 8'h1C, 8'h29, 3'b010, 1, 8'h29, 1'b0, 1'b0, 1);
    tbl[7] = mkv(2, 8'hE0, 8'hAA, 8'h00, 3'b000, 1, 8'hAA, 1'b0, 1'b1, 0);
    tbl[8] = mkv(1, 8'hE1, 8'h00, 8'h00, 3'b000, 1, 8'hE1, 1'b0, 1'b0, 0);

    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    key_ready = 1'b1;
    tick(3);
    chk("reset_outputs", {23'd0, key_valid, key_code, key_release, key_extended, frame_err,
                          overrun}, 32'd0);
    reset = 1'b0;
    tick(20);

    for (int r = 0; r < 9; r++) begin
      clear_mon();
      for (int k = 0; k < tbl[r].nf; k++) begin
        case (k)
          0: send_frame(tbl[r].f0, tbl[r].bad[0]);
          1: send_frame(tbl[r].f1, tbl[r].bad[1]);
          default: send_frame(tbl[r].f2, tbl[r].bad[2]);
        endcase
      end
      tick(20);
      chk($sformatf("row%0d_events", r), evq.size(), tbl[r].exp_n);
      if (tbl[r].exp_n > 0 && evq.size() > 0)
        chk($sformatf("row%0d_event", r), {22'd0, evq[0]},
            {22'd0, tbl[r].code, tbl[r].rel, tbl[r].ext});
      chk($sformatf("row%0d_frame_err", r), err_cnt, tbl[r].exp_err);
      if (tbl[r].exp_err > 0) chk($sformatf("row%0d_err_width", r), err_maxw, 1);
      chk($sformatf("row%0d_overrun", r), {31'd0, overrun}, 0);
    end

    // Stop-bit fall strobe to key_valid high.
    lat = -1;
    send_frame(8'h3A, 1'b0);
    tick(10);
    chk("latency", lat, 2);

    // Timeout: start + 4 data bits then silence.
    clear_mon();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    tick(300);
    chk("timeout_count", err_cnt, 1);
    chk("timeout_width", err_maxw, 1);
    chk("timeout_window", {31'd0, (err_cyc - last_fall >= 205) && (err_cyc - last_fall <= 218)},
        1);
    chk("timeout_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
    chk("timeout_no_event", evq.size(), 0);
    clear_mon();
    send_frame(8'h5A, 1'b0);
    tick(20);
    chk("after_timeout_events", evq.size(), 1);
    if (evq.size() > 0) chk("after_timeout_event", {22'd0, evq[0]}, {22'd0, 8'h5A, 2'b00});

    // Reset mid-frame with a held event pending.
    key_ready = 1'b0;
    send_frame(8'h1C, 1'b0);
    tick(10);
    chk("pre_reset_valid", {31'd0, key_valid}, 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("midframe_reset_outputs", {23'd0, key_valid, key_code, key_release, key_extended,
                                   frame_err, overrun}, 32'd0);
    chk("midframe_reset_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
    key_ready = 1'b1;
    ps2_data = 1'b1;
    tick(20);
    clear_mon();
    send_frame(8'h4B, 1'b0);
    tick(20);
    chk("after_reset_events", evq.size(), 1);
    if (evq.size() > 0) chk("after_reset_event", {22'd0, evq[0]}, {22'd0, 8'h4B, 2'b00});
    chk("after_reset_err", err_cnt, 0);

    // Overrun: second event dropped while the first is held.
    clear_mon();
    key_ready = 1'b0;
    send_frame(8'h1C, 1'b0);
    send_frame(8'h32, 1'b0);
    tick(20);
    chk("ovr_valid", {31'd0, key_valid}, 1);
    chk("ovr_code", {24'd0, key_code}, 32'h1C);
    chk("ovr_flag", {31'd0, overrun}, 1);
    key_ready = 1'b1;
    tick(1);
    chk("ovr_drain_valid", {31'd0, key_valid}, 0);
    tick(200);
    chk("ovr_events", evq.size(), 1);
    if (evq.size() > 0) chk("ovr_event", {22'd0, evq[0]}, {22'd0, 8'h1C, 2'b00});
    chk("ovr_sticky", {31'd0, overrun}, 1);
    chk("ovr_code_hold", {24'd0, key_code}, 32'h1C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
